enemy_spawn_scheduler: RTL

- Central scheduler for the per-enemy combat logic instances.
- Tracks which enemies are dead and how long each has been dead, and counts kills and waves.
- Shares one spawn channel between all dead enemies using round-robin arbitration.
- Issues one spawn grant at a time, with a spawn location chosen from fixed map corners that are not too close to the player. The grant drives each instance's revive and position load.

---
 rtl/enemy_spawn_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// enemy_spawn_scheduler
//
// Central respawn scheduler for the per-enemy combat instances. It watches the
// alive flags of every enemy slot, counts kills and waves, times how long each
// slot has been dead, and hands out one spawn grant at a time through a
// round-robin arbiter. A spawn corner is picked from the four fixed map
// corners, skipping any corner too close to the player.
//
// Optional build macro: SPAWN_WAVE_SPEEDUP_EN
//   When defined, the respawn threshold shrinks by 4 frames per wave, with a
//   floor of 8 frames. When undefined, the threshold is RESPAWN_FRAMES.
//
// Ports:
//   Clk                        system clock
//   Reset                      asynchronous, active-high reset
//   game_frame_clk_rising_edge one-Clk pulse per game frame
//   Game_Start                 pulse, leaves IDLE (ignored elsewhere)
//   Enemy_Alive[ENEMY_NUM]     alive flag per enemy slot
//   Player_X, Player_Y [9]     player position
//   Spawn_Grant[ENEMY_NUM]     one-hot, one-Clk spawn grant
//   Spawn_X, Spawn_Y [9]       spawn location, valid with grant, then held
//   Wave[4]                    current wave, saturates at 15
//   Kill_Count[8]              total kills, saturates at 255
//   Sched_State[2]             0=IDLE 1=COOLDOWN 2=ARBITRATE 3=GRANT
// ---------------------------------------------------------------------------
module enemy_spawn_scheduler #(
  parameter int ENEMY_NUM      = 4,
  parameter int RESPAWN_FRAMES = 40,
  parameter int MIN_GAP_FRAMES = 6,
  parameter int KILLS_PER_WAVE = 8,
  parameter int SAFE_DIST      = 64
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 game_frame_clk_rising_edge,
  input  logic                 Game_Start,
  input  logic [ENEMY_NUM-1:0] Enemy_Alive,
  input  logic [8:0]           Player_X,
  input  logic [8:0]           Player_Y,
  output logic [ENEMY_NUM-1:0] Spawn_Grant,
  output logic [8:0]           Spawn_X,
  output logic [8:0]           Spawn_Y,
  output logic [3:0]           Wave,
  output logic [7:0]           Kill_Count,
  output logic [1:0]           Sched_State
);

  localparam int IDX_W = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
  localparam logic [7:0]        RESP_8    = 8'(RESPAWN_FRAMES);
  localparam logic [7:0]        MIN_GAP_8 = 8'(MIN_GAP_FRAMES);
  localparam logic [7:0]        KPW_8     = 8'(KILLS_PER_WAVE);
  localparam logic signed [9:0] SAFE_10   = 10'(SAFE_DIST);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ENEMY_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COOLDOWN  = 2'd1,
    ST_ARBITRATE = 2'd2,
    ST_GRANT     = 2'd3
  } state_t;

  // Corner coordinates: 0=(16,16) 1=(464,16) 2=(16,432) 3=(464,432)
  function automatic logic [8:0] corner_x(input logic [1:0] c);
    logic [8:0] x;
    case (c)
      2'd0, 2'd2: x = 9'd16;
      2'd1, 2'd3: x = 9'd464;
      default:    x = 9'd16;
    endcase
    return x;
  endfunction

  function automatic logic [8:0] corner_y(input logic [1:0] c);
    logic [8:0] y;
    case (c)
      2'd0, 2'd1: y = 9'd16;
      2'd2, 2'd3: y = 9'd432;
      default:    y = 9'd16;
    endcase
    return y;
  endfunction

  // Differences are taken on zero-extended 10-bit signed operands, so the
  // full 0..511 range never wraps.
  function automatic logic corner_blocked(input logic [8:0] cx, input logic [8:0] cy,
                                          input logic [8:0] px, input logic [8:0] py);
    logic signed [9:0] dx, dy, adx, ady;
    dx  = $signed({1'b0, cx}) - $signed({1'b0, px});
    dy  = $signed({1'b0, cy}) - $signed({1'b0, py});
    adx = dx[9] ? -dx : dx;
    ady = dy[9] ? -dy : dy;
    return (adx < SAFE_10) && (ady < SAFE_10);
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           gap_q, gap_d, gap_inc_s;
  logic [IDX_W-1:0]     rr_q, rr_d, winner_q, winner_d;
  logic [1:0]           corner_ptr_q, corner_ptr_d, corner_q, corner_d;
  logic [ENEMY_NUM-1:0] alive_prev_q, pending_q, pending_d;
  logic [ENEMY_NUM-1:0] grant_q, grant_d;
  logic [8:0]           spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
  logic [7:0]           dead_timer_q [ENEMY_NUM];
  logic [7:0]           dead_timer_d [ENEMY_NUM];
  logic [7:0]           kill_count_q, kill_count_d;
  logic [7:0]           wave_prog_q, wave_prog_d;
  logic [3:0]           wave_q, wave_d;

  logic [ENEMY_NUM-1:0] fall_s, rise_s, elig_s;
  logic [7:0]           kill_inc_s, prog_sum_s, thr_s;
  logic [8:0]           kill_sum_s;
  logic                 granting_s;
  logic                 arb_found_s, corner_found_s;
  logic [IDX_W-1:0]     arb_win_s;
  logic [1:0]           corner_sel_s, cand_s;

  assign fall_s     = alive_prev_q & ~Enemy_Alive;
  assign rise_s     = ~alive_prev_q & Enemy_Alive;
  assign granting_s = (state_q == ST_GRANT);
  assign gap_inc_s  = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

  // Respawn threshold, optionally shortened as waves advance.
  always_comb begin
`ifdef SPAWN_WAVE_SPEEDUP_EN
    logic [7:0] wave_x4_s;
    wave_x4_s = {2'b00, wave_q, 2'b00};
    // Clamp before subtracting so the 8-bit result cannot underflow.
    if ((wave_x4_s + 8'd8) > RESP_8) begin
      thr_s = 8'd8;
    end else begin
      thr_s = RESP_8 - wave_x4_s;
    end
`else
    thr_s = RESP_8;
`endif
  end

  // Kill counting and wave advance from alive-flag falling edges.
  always_comb begin
    kill_inc_s = 8'd0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      kill_inc_s = kill_inc_s + {7'd0, fall_s[i]};
    end
    kill_sum_s   = {1'b0, kill_count_q} + {1'b0, kill_inc_s};
    kill_count_d = kill_sum_s[8] ? 8'hFF : kill_sum_s[7:0];
    // wave_prog_q holds kills since the last multiple of KILLS_PER_WAVE.
    prog_sum_s = wave_prog_q + kill_inc_s;
    if (prog_sum_s >= KPW_8) begin
      wave_prog_d = prog_sum_s - KPW_8;
      wave_d      = (wave_q == 4'd15) ? wave_q : wave_q + 4'd1;
    end else begin
      wave_prog_d = prog_sum_s;
      wave_d      = wave_q;
    end
  end

  // Per-slot dead timers, pending flags and eligibility.
  always_comb begin
    for (int i = 0; i < ENEMY_NUM; i++) begin
      if (granting_s && (winner_q == IDX_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (rise_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end

      if (Enemy_Alive[i]) begin
        dead_timer_d[i] = 8'd0;
      end else if (granting_s && (winner_q == IDX_W'(i))) begin
        dead_timer_d[i] = 8'd0;
      end else if (game_frame_clk_rising_edge && (dead_timer_q[i] != 8'hFF)) begin
        dead_timer_d[i] = dead_timer_q[i] + 8'd1;
      end else begin
        dead_timer_d[i] = dead_timer_q[i];
      end

      elig_s[i] = ~Enemy_Alive[i] & ~pending_q[i] & (dead_timer_q[i] >= thr_s);
    end
  end

  // Round-robin winner search and first unblocked corner search.
  always_comb begin
    arb_found_s    = 1'b0;
    arb_win_s      = '0;
    corner_found_s = 1'b0;
    corner_sel_s   = 2'd0;
    cand_s         = 2'd0;
    for (int k = 0; k < ENEMY_NUM; k++) begin
      if (!arb_found_s && elig_s[(int'(rr_q) + k) % ENEMY_NUM]) begin
        arb_found_s = 1'b1;
        arb_win_s   = IDX_W'((int'(rr_q) + k) % ENEMY_NUM);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
    for (int k = 0; k < 4; k++) begin
      cand_s = corner_ptr_q + 2'(k);
      if (!corner_found_s &&
          !corner_blocked(corner_x(cand_s), corner_y(cand_s), Player_X, Player_Y)) begin
        corner_found_s = 1'b1;
        corner_sel_s   = cand_s;
      end else begin
        corner_found_s = corner_found_s;
      end
    end
  end

  // Scheduler FSM next-state and registered-output preparation.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    rr_d         = rr_q;
    winner_d     = winner_q;
    corner_ptr_d = corner_ptr_q;
    corner_d     = corner_q;
    spawn_x_d    = spawn_x_q;
    spawn_y_d    = spawn_y_q;
    grant_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (Game_Start) begin
          state_d = ST_COOLDOWN;
          gap_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        // The frame pulse that brings the gap up to MIN_GAP_FRAMES triggers
        // arbitration, so grants land exactly MIN_GAP_FRAMES frames apart.
        if (game_frame_clk_rising_edge) begin
          gap_d = gap_inc_s;
          if (gap_inc_s >= MIN_GAP_8) begin
            state_d = ST_ARBITRATE;
          end else begin
            state_d = ST_COOLDOWN;
          end
        end else begin
          state_d = ST_COOLDOWN;
        end
      end
      ST_ARBITRATE: begin
        if (arb_found_s && corner_found_s) begin
          state_d   = ST_GRANT;
          winner_d  = arb_win_s;
          corner_d  = corner_sel_s;
          spawn_x_d = corner_x(corner_sel_s);
          spawn_y_d = corner_y(corner_sel_s);
          grant_d   = {{(ENEMY_NUM-1){1'b0}}, 1'b1} << arb_win_s;
        end else begin
          // Gap is kept, so the next frame pulse retries immediately.
          state_d = ST_COOLDOWN;
        end
      end
      ST_GRANT: begin
        state_d      = ST_COOLDOWN;
        gap_d        = 8'd0;
        rr_d         = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
        corner_ptr_d = corner_q + 2'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      gap_q        <= 8'd0;
      rr_q         <= '0;
      winner_q     <= '0;
      corner_ptr_q <= 2'd0;
      corner_q     <= 2'd0;
      alive_prev_q <= '0;
      pending_q    <= '0;
      grant_q      <= '0;
      spawn_x_q    <= 9'd0;
      spawn_y_q    <= 9'd0;
      kill_count_q <= 8'd0;
      wave_prog_q  <= 8'd0;
      wave_q       <= 4'd0;
      for (int i = 0; i < ENEMY_NUM; i++) begin
        dead_timer_q[i] <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      rr_q         <= rr_d;
      winner_q     <= winner_d;
      corner_ptr_q <= corner_ptr_d;
      corner_q     <= corner_d;
      alive_prev_q <= Enemy_Alive;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      spawn_x_q    <= spawn_x_d;
      spawn_y_q    <= spawn_y_d;
      kill_count_q <= kill_count_d;
      wave_prog_q  <= wave_prog_d;
      wave_q       <= wave_d;
      dead_timer_q <= dead_timer_d;
    end
  end

  assign Spawn_Grant = grant_q;
  assign Spawn_X     = spawn_x_q;
  assign Spawn_Y     = spawn_y_q;
  assign Wave        = wave_q;
  assign Kill_Count  = kill_count_q;
  assign Sched_State = state_q;

endmodule
